// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
// Optional feature macro: CMP_HAMMING_EN (Hamming-distance output).
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // Number of slices scanned per compare.
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Bits needed to hold a population count of 0..width.
  function automatic int hd_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/slice_cmp.sv
// Combinational single-slice comparator: inequality, greater-than (with
// optional sign-bit inversion for the top slice) and, with CMP_HAMMING_EN,
// the popcount of the slice difference.
module slice_cmp
  import cmp_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0]         sa,
  input  logic [SLICE-1:0]         sb,
  input  logic                     msb_inv,
  output logic                     neq,
  output logic                     gt
`ifdef CMP_HAMMING_EN
  ,
  output logic [hd_w(SLICE)-1:0]   popcnt
`endif
);

`ifdef CMP_HAMMING_EN
  localparam int PW = hd_w(SLICE);
  logic [SLICE-1:0] w_x;
`endif
  logic [SLICE-1:0] w_msk;

  // Inverting the MSB of both operands turns a two's-complement compare into an unsigned one.
  always_comb begin
    w_msk          = '0;
    w_msk[SLICE-1] = msb_inv;
    neq            = (sa != sb);
    gt             = ((sa ^ w_msk) > (sb ^ w_msk));
  end

`ifdef CMP_HAMMING_EN
  // Count differing bits within the slice.
  always_comb begin
    w_x    = sa ^ sb;
    popcnt = '0;
    for (int unsigned i = 0; i < SLICE; i++) begin
      popcnt = popcnt + PW'(w_x[i]);
    end
  end
`endif

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude/equality comparator, scanning SLICE bits
// per clock MSB slice first. Optional feature macro: CMP_HAMMING_EN adds the
// hd output (Hamming distance of a^b).
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SLICE  = 4,
  parameter int SIGNED = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  output logic                    busy,
  output logic                    done,
  output logic                    eq,
  output logic                    lt,
  output logic                    gt
`ifdef CMP_HAMMING_EN
  ,
  output logic [hd_w(WIDTH)-1:0]  hd
`endif
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE) != 0) begin : g_width_chk
    $error("seq_mag_comparator: WIDTH must be a multiple of SLICE");
  end

  cmp_state_t        r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [IDXW-1:0]   r_idx;
  logic              r_decided;
  logic              r_gt_w;
  logic              r_lt_w;
  logic              r_busy;
  logic              r_done;
  logic              r_eq;
  logic              r_lt;
  logic              r_gt;

  logic              w_msb_inv;
  logic              w_neq;
  logic              w_gt;
  logic              w_dec_n;
  logic              w_gt_n;
  logic              w_lt_n;

`ifdef CMP_HAMMING_EN
  localparam int HDW = hd_w(WIDTH);
  localparam int PW  = hd_w(SLICE);
  logic [HDW-1:0]    r_hd_acc;
  logic [HDW-1:0]    r_hd;
  logic [PW-1:0]     w_pc;
  logic [HDW-1:0]    w_hd_n;
`endif

  // Working operands are shifted left each cycle, so the current slice is always the top one.
  slice_cmp #(
    .SLICE (SLICE)
  ) u_slice (
    .sa      (r_a[WIDTH-1 -: SLICE]),
    .sb      (r_b[WIDTH-1 -: SLICE]),
    .msb_inv (w_msb_inv),
    .neq     (w_neq),
    .gt      (w_gt)
`ifdef CMP_HAMMING_EN
    ,
    .popcnt  (w_pc)
`endif
  );

  // Decision after including the current slice; the first differing slice wins.
  always_comb begin
    w_msb_inv = (SIGNED != 0) && (r_idx == IDXW'(NSLICE - 1));
    w_dec_n   = r_decided | w_neq;
    w_gt_n    = r_decided ? r_gt_w : (w_neq & w_gt);
    w_lt_n    = r_decided ? r_lt_w : (w_neq & ~w_gt);
`ifdef CMP_HAMMING_EN
    w_hd_n    = r_hd_acc + HDW'(w_pc);
`endif
  end

  // Control FSM, slice scan and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_gt_w    <= 1'b0;
      r_lt_w    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_gt      <= 1'b0;
`ifdef CMP_HAMMING_EN
      r_hd_acc  <= '0;
      r_hd      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_idx     <= IDXW'(NSLICE - 1);
            r_decided <= 1'b0;
            r_gt_w    <= 1'b0;
            r_lt_w    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
`ifdef CMP_HAMMING_EN
            r_hd_acc  <= '0;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a       <= r_a << SLICE;
          r_b       <= r_b << SLICE;
          r_idx     <= r_idx - IDXW'(1);
          r_decided <= w_dec_n;
          r_gt_w    <= w_gt_n;
          r_lt_w    <= w_lt_n;
`ifdef CMP_HAMMING_EN
          r_hd_acc  <= w_hd_n;
`endif
          if (r_idx == '0) begin
            r_eq    <= ~w_dec_n;
            r_gt    <= w_gt_n;
            r_lt    <= w_lt_n;
`ifdef CMP_HAMMING_EN
            r_hd    <= w_hd_n;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign eq   = r_eq;
  assign lt   = r_lt;
  assign gt   = r_gt;
`ifdef CMP_HAMMING_EN
  assign hd   = r_hd;
`endif

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator (WIDTH=8, SLICE=2), unsigned and signed
// instances driven in parallel; hd checked when CMP_HAMMING_EN is defined.
module tb_seq_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, eq, lt, gt;
  logic       s_busy, s_done, s_eq, s_lt, s_gt;
  logic [3:0] hd, s_hd;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] elg_u;
    logic [2:0] elg_s;
    logic [3:0] hd;
  } exp_t;

  exp_t sb_q[$];

  seq_mag_comparator #(.WIDTH(8), .SLICE(2), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt)
`ifdef CMP_HAMMING_EN
    , .hd(hd)
`endif
  );

  seq_mag_comparator #(.WIDTH(8), .SLICE(2), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(s_busy), .done(s_done), .eq(s_eq), .lt(s_lt), .gt(s_gt)
`ifdef CMP_HAMMING_EN
    , .hd(s_hd)
`endif
  );

`ifndef CMP_HAMMING_EN
  assign hd   = '0;
  assign s_hd = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb);
    exp_t e;
    e.a     = ma;
    e.b     = mb;
    e.elg_u = {ma == mb, ma < mb, ma > mb};
    e.elg_s = {ma == mb, $signed(ma) < $signed(mb), $signed(ma) > $signed(mb)};
    e.hd    = 4'($countones(ma ^ mb));
    return e;
  endfunction

  // Drive a start right now (caller is between edges) and log expected result.
  task automatic issue_now(input logic [7:0] ia, input logic [7:0] ib);
    a = ia;
    b = ib;
    start = 1'b1;
    sb_q.push_back(model(ia, ib));
    @(posedge clk);
    #1;
    t_start = cyc;
    start = 1'b0;
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib);
    @(negedge clk);
    issue_now(ia, ib);
  endtask

  // Wait (bounded) for done; returns edges since the accepted start.
  task automatic wait_done(output int lat, output bit tout);
    lat  = 0;
    tout = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) begin
        tout = 1'b0;
        lat  = cyc - t_start;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, eq, lt, gt, hd} !== 9'b0)
      begin n_err++; $display("FAIL reset_u: got %b want 0", {busy, done, eq, lt, gt, hd}); end
    n_cmp++;
    if ({s_busy, s_done, s_eq, s_lt, s_gt, s_hd} !== 9'b0)
      begin n_err++; $display("FAIL reset_s: got %b want 0", {s_busy, s_done, s_eq, s_lt, s_gt, s_hd}); end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, eq, lt, gt} !== 5'b0)
      begin n_err++; $display("FAIL idle_after_reset: got %b want 0", {busy, done, eq, lt, gt}); end
  endtask

  task automatic test_equal;
    exp_t e;
    issue(8'hA5, 8'hA5);
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if ({busy, done} !== 2'b10)
        begin n_err++; $display("FAIL equal_busy[%0d]: busy,done=%b want 10", i, {busy, done}); end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({busy, done} !== 2'b01)
      begin n_err++; $display("FAIL equal_done: busy,done=%b want 01", {busy, done}); end
    e = sb_q.pop_front();
    n_cmp++;
    if ({eq, lt, gt} !== e.elg_u || {eq, lt, gt} !== 3'b100)
      begin n_err++; $display("FAIL equal_elg: got %b want %b", {eq, lt, gt}, e.elg_u); end
`ifdef CMP_HAMMING_EN
    n_cmp++;
    if (hd !== e.hd)
      begin n_err++; $display("FAIL equal_hd: got %0d want %0d", hd, e.hd); end
`endif
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done, eq, lt, gt} !== 4'b0100)
      begin n_err++; $display("FAIL equal_pulse_hold: done,eq,lt,gt=%b want 0100", {done, eq, lt, gt}); end
  endtask

  task automatic test_gt;
    exp_t e;
    int lat;
    bit tout;
    issue(8'h0A, 8'h05);
    n_cmp++;
    if ({eq, lt, gt} !== 3'b100)
      begin n_err++; $display("FAIL gt_hold_in_run: got %b want 100", {eq, lt, gt}); end
    wait_done(lat, tout);
    n_cmp++;
    if (tout || lat != 4)
      begin n_err++; $display("FAIL gt_latency: got %0d (timeout %0d) want 4", lat, tout); end
    e = sb_q.pop_front();
    n_cmp++;
    if ({eq, lt, gt} !== e.elg_u)
      begin n_err++; $display("FAIL gt_elg: got %b want %b", {eq, lt, gt}, e.elg_u); end
`ifdef CMP_HAMMING_EN
    n_cmp++;
    if (hd !== e.hd)
      begin n_err++; $display("FAIL gt_hd: got %0d want %0d", hd, e.hd); end
`endif
  endtask

  task automatic test_signed;
    exp_t e;
    int lat;
    bit tout;
    issue(8'h80, 8'h01);
    wait_done(lat, tout);
    n_cmp++;
    if (tout || lat != 4 || s_done !== 1'b1)
      begin n_err++; $display("FAIL signed_latency: got %0d s_done %b want 4/1", lat, s_done); end
    e = sb_q.pop_front();
    n_cmp++;
    if ({eq, lt, gt} !== e.elg_u)
      begin n_err++; $display("FAIL unsigned_80_01: got %b want %b", {eq, lt, gt}, e.elg_u); end
    n_cmp++;
    if ({s_eq, s_lt, s_gt} !== e.elg_s)
      begin n_err++; $display("FAIL signed_80_01: got %b want %b", {s_eq, s_lt, s_gt}, e.elg_s); end
`ifdef CMP_HAMMING_EN
    n_cmp++;
    if (hd !== e.hd || s_hd !== e.hd)
      begin n_err++; $display("FAIL signed_hd: got %0d/%0d want %0d", hd, s_hd, e.hd); end
`endif
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int lat;
    bit tout;
    int extra;
    issue(8'h01, 8'h02);
    @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, tout);
    n_cmp++;
    if (tout || lat != 4)
      begin n_err++; $display("FAIL ignore_latency: got %0d (timeout %0d) want 4", lat, tout); end
    e = sb_q.pop_front();
    n_cmp++;
    if ({eq, lt, gt} !== e.elg_u || {s_eq, s_lt, s_gt} !== e.elg_s)
      begin n_err++; $display("FAIL ignore_elg: got %b/%b want %b/%b", {eq, lt, gt}, {s_eq, s_lt, s_gt}, e.elg_u, e.elg_s); end
`ifdef CMP_HAMMING_EN
    n_cmp++;
    if (hd !== e.hd)
      begin n_err++; $display("FAIL ignore_hd: got %0d want %0d", hd, e.hd); end
`endif
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    n_cmp++;
    if (extra != 0)
      begin n_err++; $display("FAIL ignore_no_queue: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_midrun;
    int dones;
    issue(8'h33, 8'h44);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    n_cmp++;
    if ({busy, done, eq, lt, gt, hd} !== 9'b0 || {s_busy, s_done, s_eq, s_lt, s_gt} !== 5'b0)
      begin n_err++; $display("FAIL midrun_reset: got %b/%b want 0", {busy, done, eq, lt, gt, hd}, {s_busy, s_done, s_eq, s_lt, s_gt}); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done || s_done || busy) dones++;
    end
    n_cmp++;
    if (dones != 0)
      begin n_err++; $display("FAIL midrun_no_done: got %0d active cycles want 0", dones); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int lat;
    bit tout;
    issue(8'h12, 8'h34);
    wait_done(lat, tout);
    n_cmp++;
    if (tout || lat != 4)
      begin n_err++; $display("FAIL b2b_first_latency: got %0d (timeout %0d) want 4", lat, tout); end
    e = sb_q.pop_front();
    n_cmp++;
    if ({eq, lt, gt} !== e.elg_u)
      begin n_err++; $display("FAIL b2b_first_elg: got %b want %b", {eq, lt, gt}, e.elg_u); end
    issue_now(8'hFF, 8'h00);
    n_cmp++;
    if ({busy, done} !== 2'b10)
      begin n_err++; $display("FAIL b2b_accept: busy,done=%b want 10", {busy, done}); end
    wait_done(lat, tout);
    n_cmp++;
    if (tout || lat != 4)
      begin n_err++; $display("FAIL b2b_latency: got %0d (timeout %0d) want 4", lat, tout); end
    e = sb_q.pop_front();
    n_cmp++;
    if ({eq, lt, gt} !== e.elg_u || {s_eq, s_lt, s_gt} !== e.elg_s)
      begin n_err++; $display("FAIL b2b_elg: got %b/%b want %b/%b", {eq, lt, gt}, {s_eq, s_lt, s_gt}, e.elg_u, e.elg_s); end
`ifdef CMP_HAMMING_EN
    n_cmp++;
    if (hd !== e.hd)
      begin n_err++; $display("FAIL b2b_hd: got %0d want %0d", hd, e.hd); end
`endif
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt();
    test_signed();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
